// File: rtl/rgmii_rx_frame_if.sv
// Bundle of RGMII receive inputs and decoded GMII / frame / status outputs.
// The master drives the realigned RGMII samples; the slave (the decoder) drives everything else.
// Handshake: frame_valid is a one-cycle strobe per payload byte with no ready signal.
// The consumer must take every frame_valid cycle. frame_sop, frame_eop, frame_err and frame_len
// are qualified by frame_valid; frame_err and frame_len are meaningful only with frame_eop.
interface rgmii_rx_frame_if;
    logic [3:0]  rx_data_rise;
    logic [3:0]  rx_data_fall;
    logic        rx_ctl_rise;
    logic        rx_ctl_fall;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  gmii_rx_data;
    logic        frame_valid;
    logic [7:0]  frame_data;
    logic        frame_sop;
    logic        frame_eop;
    logic        frame_err;
    logic [15:0] frame_len;
    logic        link_up;
    logic [1:0]  link_speed;
    logic        full_duplex;
    logic [15:0] drop_cnt;

    modport master (
        output rx_data_rise, rx_data_fall, rx_ctl_rise, rx_ctl_fall,
        input  gmii_rx_dv, gmii_rx_er, gmii_rx_data,
        input  frame_valid, frame_data, frame_sop, frame_eop, frame_err, frame_len,
        input  link_up, link_speed, full_duplex, drop_cnt
    );

    modport slave (
        input  rx_data_rise, rx_data_fall, rx_ctl_rise, rx_ctl_fall,
        output gmii_rx_dv, gmii_rx_er, gmii_rx_data,
        output frame_valid, frame_data, frame_sop, frame_eop, frame_err, frame_len,
        output link_up, link_speed, full_duplex, drop_cnt
    );
endinterface

// File: rtl/rgmii_rx_frame.sv
// RGMII receive decoder: rebuilds GMII bytes, strips preamble/SFD, delimits payload with
// SOP/EOP through a one-byte hold register, measures length, flags errors, counts dropped
// frames and tracks in-band link status. Everything runs on the rising edge of gmii_rx_clk.
module rgmii_rx_frame #(
    parameter int MIN_PREAMBLE = 1,
    parameter int MAX_FRAME    = 1522
) (
    input  logic            gmii_rx_clk,
    input  logic            sys_rst,
    rgmii_rx_frame_if.slave bus,
    output logic [1:0]      fsm_state_o
);
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_PAYLOAD  = 2'd2,
        S_DROP     = 2'd3
    } state_t;

    localparam logic [2:0]  MIN_PRE = 3'(MIN_PREAMBLE);
    localparam logic [15:0] MAX_LEN = 16'(MAX_FRAME);

    // Stage 1 decoded GMII
    logic       s1_dv_q, s1_er_q;
    logic [7:0] s1_data_q;
    // In-band status nibble
    logic [3:0] status_q;

    // Frame FSM state
    state_t      state_q, state_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic [15:0] len_q, len_d, len_inc;
    logic        err_q, err_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        first_q, first_d;
    logic [15:0] drop_q, drop_d;
    logic        drop_inc;

    // Registered frame outputs
    logic        fv_q, fv_d;
    logic [7:0]  fd_q, fd_d;
    logic        fsop_q, fsop_d;
    logic        feop_q, feop_d;
    logic        ferr_q, ferr_d;
    logic [15:0] flen_q, flen_d;

    // Stage 1: rebuild the byte and decode DV/ER from the two RX_CTL samples.
    always_ff @(posedge gmii_rx_clk) begin
        if (sys_rst) begin
            s1_dv_q   <= 1'b0;
            s1_er_q   <= 1'b0;
            s1_data_q <= 8'h00;
        end else begin
            s1_dv_q   <= bus.rx_ctl_rise;
            s1_er_q   <= bus.rx_ctl_rise ^ bus.rx_ctl_fall;
            s1_data_q <= {bus.rx_data_fall, bus.rx_data_rise};
        end
    end

    // Capture in-band status only from clean idle samples whose two nibbles agree.
    always_ff @(posedge gmii_rx_clk) begin
        if (sys_rst) begin
            status_q <= 4'h0;
        end else if (!s1_dv_q && !s1_er_q && (s1_data_q[3:0] == s1_data_q[7:4])) begin
            status_q <= s1_data_q[3:0];
        end
    end

    // Frame FSM next state; a payload byte is released only once the next sample is seen,
    // so the last byte can be tagged EOP when dv drops.
    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        len_d      = len_q;
        err_d      = err_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        first_d    = first_q;
        fv_d       = 1'b0;
        fd_d       = 8'h00;
        fsop_d     = 1'b0;
        feop_d     = 1'b0;
        ferr_d     = 1'b0;
        flen_d     = 16'h0000;
        drop_inc   = 1'b0;
        len_inc    = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (s1_dv_q) begin
                    if (s1_er_q || (s1_data_q != 8'h55)) begin
                        state_d  = S_DROP;
                        drop_inc = 1'b1;
                    end else begin
                        state_d   = S_PREAMBLE;
                        pre_cnt_d = 3'd1;
                    end
                end
            end
            S_PREAMBLE: begin
                if (!s1_dv_q) begin
                    state_d = S_IDLE;
                end else if (s1_er_q) begin
                    state_d  = S_DROP;
                    drop_inc = 1'b1;
                end else if (s1_data_q == 8'h55) begin
                    pre_cnt_d = (pre_cnt_q == 3'd7) ? pre_cnt_q : pre_cnt_q + 3'd1;
                end else if ((s1_data_q == 8'hD5) && (pre_cnt_q >= MIN_PRE)) begin
                    state_d    = S_PAYLOAD;
                    len_d      = 16'h0000;
                    err_d      = 1'b0;
                    hold_vld_d = 1'b0;
                    first_d    = 1'b1;
                end else begin
                    state_d  = S_DROP;
                    drop_inc = 1'b1;
                end
            end
            S_PAYLOAD: begin
                if (s1_dv_q) begin
                    hold_d     = s1_data_q;
                    hold_vld_d = 1'b1;
                    len_d      = len_inc;
                    err_d      = err_q | s1_er_q | (len_inc > MAX_LEN);
                    if (hold_vld_q) begin
                        fv_d    = 1'b1;
                        fd_d    = hold_q;
                        fsop_d  = first_q;
                        first_d = 1'b0;
                    end
                end else begin
                    state_d    = S_IDLE;
                    hold_vld_d = 1'b0;
                    if (hold_vld_q) begin
                        fv_d   = 1'b1;
                        fd_d   = hold_q;
                        fsop_d = first_q;
                        feop_d = 1'b1;
                        ferr_d = err_q;
                        flen_d = len_q;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            S_DROP: begin
                if (!s1_dv_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        drop_d = (drop_inc && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
    end

    // Frame FSM state, counters and output registers.
    always_ff @(posedge gmii_rx_clk) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            pre_cnt_q  <= 3'd0;
            len_q      <= 16'h0000;
            err_q      <= 1'b0;
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
            first_q    <= 1'b0;
            drop_q     <= 16'h0000;
            fv_q       <= 1'b0;
            fd_q       <= 8'h00;
            fsop_q     <= 1'b0;
            feop_q     <= 1'b0;
            ferr_q     <= 1'b0;
            flen_q     <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            len_q      <= len_d;
            err_q      <= err_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            first_q    <= first_d;
            drop_q     <= drop_d;
            fv_q       <= fv_d;
            fd_q       <= fd_d;
            fsop_q     <= fsop_d;
            feop_q     <= feop_d;
            ferr_q     <= ferr_d;
            flen_q     <= flen_d;
        end
    end

    assign bus.gmii_rx_dv   = s1_dv_q;
    assign bus.gmii_rx_er   = s1_er_q;
    assign bus.gmii_rx_data = s1_data_q;
    assign bus.frame_valid  = fv_q;
    assign bus.frame_data   = fd_q;
    assign bus.frame_sop    = fsop_q;
    assign bus.frame_eop    = feop_q;
    assign bus.frame_err    = ferr_q;
    assign bus.frame_len    = flen_q;
    assign bus.link_up      = status_q[0];
    assign bus.link_speed   = status_q[2:1];
    assign bus.full_duplex  = status_q[3];
    assign bus.drop_cnt     = drop_q;
    assign fsm_state_o      = state_q;
endmodule

// File: tb/tb_rgmii_rx_frame.sv
// Bench for rgmii_rx_frame: directed and random frames, checked against a run-based
// frame model (each dv=1 run is parsed as preamble/SFD/payload) and a stage/status timing model.
module tb_rgmii_rx_frame;
    localparam int MIN_PRE = 1;
    localparam int MAX_LEN = 1522;
    localparam int EW      = 59;  // {edge[31:0], len[15:0], err, eop, sop, data[7:0]}

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        sys_rst;
    logic [1:0]  fsm_state;
    int unsigned cyc = 0;

    rgmii_rx_frame_if bus ();

    rgmii_rx_frame #(.MIN_PREAMBLE(MIN_PRE), .MAX_FRAME(MAX_LEN)) dut (
        .gmii_rx_clk (clk),
        .sys_rst     (sys_rst),
        .bus         (bus),
        .fsm_state_o (fsm_state)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_total = 0;
    int n_bad   = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] obs_q[$];
    logic [40:0]   run_q[$];    // {capture edge[31:0], er, data[7:0]}
    int            m_drops = 0;
    logic [9:0]    m_s1 = '0;   // {dv, er, data} expected in stage 1
    logic [3:0]    m_stat = '0;
    bit            p_dv = 1'b0, p_er = 1'b0, p_rst = 1'b1;
    logic [7:0]    p_data = 8'h00;
    logic [7:0]    idle_byte = 8'h00;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Parse one dv run. cut=1: run truncated by reset, bytes still in flight are lost, no EOP.
    task automatic parse_run(input bit cut);
        int n, i, cnt, m;
        bit sfd, err, lst;
        logic [40:0] s;
        logic [31:0] ed;
        logic [15:0] len;
        n = run_q.size(); i = 0; cnt = 0; sfd = 1'b0;
        while (i < n && !sfd) begin
            s = run_q[i];
            if (s[8]) begin
                if (m_drops < 65535) m_drops++;
                return;
            end
            if (s[7:0] == 8'h55) begin
                cnt++; i++;
            end else if (s[7:0] == 8'hD5 && cnt >= MIN_PRE) begin
                sfd = 1'b1; i++;
            end else begin
                if (m_drops < 65535) m_drops++;
                return;
            end
        end
        if (!sfd) return;
        m = n - i;
        if (cut) begin
            for (int k = i; k < n - 1; k++) begin
                ed = run_q[k][40:9] + 32'd2;
                exp_q.push_back({ed, 16'h0000, 1'b0, 1'b0, (k == i), run_q[k][7:0]});
            end
            return;
        end
        if (m == 0) begin
            if (m_drops < 65535) m_drops++;
            return;
        end
        err = (m > MAX_LEN);
        for (int k = i; k < n; k++) err = err | run_q[k][8];
        len = (m > 65535) ? 16'hFFFF : 16'(m);
        for (int k = i; k < n; k++) begin
            lst = (k == n - 1);
            ed  = run_q[k][40:9] + 32'd2;
            exp_q.push_back({ed, (lst ? len : 16'h0000), (lst & err), lst, (k == i), run_q[k][7:0]});
        end
    endtask

    // Check outputs produced by the edge just passed, against the sample presented for it.
    task automatic check_cycle();
        logic [9:0] ns1;
        logic [3:0] nstat;
        if (p_rst) begin
            ns1 = '0; nstat = '0;
        end else begin
            ns1 = {p_dv, p_er, p_data};
            nstat = (!m_s1[9] && !m_s1[8] && (m_s1[3:0] == m_s1[7:4])) ? m_s1[3:0] : m_stat;
        end
        chk("gmii", 64'({bus.gmii_rx_dv, bus.gmii_rx_er, bus.gmii_rx_data}), 64'(ns1));
        chk("status", 64'({bus.full_duplex, bus.link_speed, bus.link_up}), 64'(nstat));
        m_s1 = ns1; m_stat = nstat;
        if (bus.frame_valid === 1'b1)
            obs_q.push_back({32'(cyc), bus.frame_len, bus.frame_err, bus.frame_eop,
                             bus.frame_sop, bus.frame_data});
        else
            chk("idle_quals", 64'({bus.frame_valid, bus.frame_sop, bus.frame_eop,
                                   bus.frame_err, bus.frame_len}), 64'(0));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input bit dv, input bit er, input logic [7:0] d, input bit rst);
        logic [31:0] e;
        @(negedge clk);
        check_cycle();
        bus.rx_ctl_rise  = dv;
        bus.rx_ctl_fall  = dv ^ er;
        bus.rx_data_rise = d[3:0];
        bus.rx_data_fall = d[7:4];
        sys_rst          = rst;
        p_dv = dv; p_er = er; p_data = d; p_rst = rst;
        e = 32'(cyc + 1);
        if (rst) begin
            if (run_q.size() > 0) begin
                void'(run_q.pop_back());
                parse_run(1'b1);
            end
            run_q.delete();
            m_drops = 0;
        end else if (dv) begin
            run_q.push_back({e, er, d});
        end else if (run_q.size() > 0) begin
            parse_run(1'b0);
            run_q.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, idle_byte, 1'b0);
    endtask

    task automatic send_frame(input int pre, input logic [7:0] sfd, input int len,
                              input int er_at, input bit rnd);
        logic [7:0] d;
        for (int k = 0; k < pre; k++) drive(1'b1, 1'b0, 8'h55, 1'b0);
        drive(1'b1, 1'b0, sfd, 1'b0);
        for (int k = 0; k < len; k++) begin
            d = rnd ? 8'($urandom_range(0, 255)) : 8'(k);
            drive(1'b1, (k == er_at), d, 1'b0);
        end
    endtask

    task automatic settle();
        idle(6);
        while (exp_q.size() > 0 && obs_q.size() > 0)
            chk("frame_byte", 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
        chk("missing_bytes", 64'(exp_q.size()), 64'(0));
        chk("extra_bytes", 64'(obs_q.size()), 64'(0));
        exp_q.delete(); obs_q.delete();
        chk("drop_cnt", 64'(bus.drop_cnt), 64'(m_drops));
        chk("fsm_idle", 64'(fsm_state), 64'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        int len;
        int er_at;
        sys_rst = 1'b1;
        bus.rx_ctl_rise = 1'b0; bus.rx_ctl_fall = 1'b0;
        bus.rx_data_rise = 4'h0; bus.rx_data_fall = 4'h0;
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        settle();

        // Clean 64-byte frame, then same frame with an error on payload byte 10
        send_frame(7, 8'hD5, 64, -1, 1'b0);
        settle();
        send_frame(7, 8'hD5, 64, 10, 1'b0);
        settle();

        // Bad preamble followed by a clean frame
        drive(1'b1, 1'b0, 8'h55, 1'b0);
        drive(1'b1, 1'b0, 8'h54, 1'b0);
        repeat (20) drive(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
        settle();
        send_frame(7, 8'hD5, 64, -1, 1'b0);
        settle();

        // In-band status
        idle_byte = 8'hDD;
        idle(3);
        chk("link_up", 64'(bus.link_up), 64'(1));
        chk("link_speed", 64'(bus.link_speed), 64'(2));
        chk("full_duplex", 64'(bus.full_duplex), 64'(1));
        idle_byte = 8'h31;
        idle(3);
        chk("status_hold", 64'({bus.full_duplex, bus.link_speed, bus.link_up}), 64'(4'hD));
        idle_byte = 8'h00;
        settle();

        // Reset pulse at payload byte 30, then a normal frame
        for (int k = 0; k < 7; k++) drive(1'b1, 1'b0, 8'h55, 1'b0);
        drive(1'b1, 1'b0, 8'hD5, 1'b0);
        for (int k = 0; k < 64; k++) drive(1'b1, 1'b0, 8'(k), (k == 30));
        settle();
        send_frame(7, 8'hD5, 64, -1, 1'b0);
        settle();

        // SFD straight into idle, then an oversize frame
        send_frame(7, 8'hD5, 0, -1, 1'b0);
        settle();
        send_frame(7, 8'hD5, 1600, -1, 1'b1);
        settle();

        // Random frames with short gaps and random idle status nibbles
        for (int f = 0; f < 30; f++) begin
            len   = $urandom_range(0, 80);
            er_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 80) : -1;
            send_frame($urandom_range(0, 7), ($urandom_range(0, 9) == 0) ? 8'hD4 : 8'hD5,
                       len, er_at, 1'b1);
            gap = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                idle_byte[3:0] = 4'($urandom_range(0, 15));
                idle_byte[7:4] = idle_byte[3:0];
            end else begin
                idle_byte = 8'($urandom_range(0, 255));
            end
            idle(gap);
        end
        idle_byte = 8'h00;
        settle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/rgmii_rx_frame.md
# rgmii_rx_frame

Receive-side counterpart to the RGMII transmit path: accepts RGMII receive nibbles and control already captured on both clock edges and realigned to the rising edge, then rebuilds the GMII byte stream (`gmii_rx_dv`, `gmii_rx_er`, `gmii_rx_data`). It also strips preamble/SFD, delimits frames with SOP/EOP, measures length, flags errors and decodes RGMII in-band link status. It sits between the receive I/O capture and the MAC receive logic, entirely in the `gmii_rx_clk` domain.

## Interface
- `MIN_PREAMBLE`, 1: minimum number of 0x55 bytes before SFD (legal 1..7).
- `MAX_FRAME`, 1522: payload byte count above which the frame is flagged as an error.

- `gmii_rx_clk`  in  1  receive clock, 125 MHz; all logic on rising edge.
- `sys_rst`  in  1  synchronous reset, active-high.
- `rx_data_rise`  in  4  RXD sampled on rising edge (byte bits 3:0).
- `rx_data_fall`  in  4  RXD sampled on falling edge (byte bits 7:4).
- `rx_ctl_rise`  in  1  RX_CTL rising-edge sample (DV).
- `rx_ctl_fall`  in  1  RX_CTL falling-edge sample (DV xor ER).
- `gmii_rx_dv`, `gmii_rx_er`  out  1 each  decoded GMII control.
- `gmii_rx_data`  out  8  decoded GMII byte.
- `frame_valid`  out  1  payload byte valid.
- `frame_data`  out  8  payload byte.
- `frame_sop`, `frame_eop`  out  1 each  first / last payload byte, qualified by `frame_valid`.
- `frame_err`  out  1  frame had an error; valid with `frame_eop`.
- `frame_len`  out  16  payload byte count; valid with `frame_eop`.
- `link_up`  out  1  in-band link status.
- `link_speed`  out  2  in-band speed: 0 = 10M, 1 = 100M, 2 = 1000M.
- `full_duplex`  out  1  in-band duplex.
- `drop_cnt`  out  16  discarded-frame counter, saturating at 0xFFFF.

## Operation
- **Reset.** All outputs and counters are 0; the FSM is in IDLE; the hold register is empty.
- **Stage 1 decode (registered).**
  - `gmii_rx_data = {rx_data_fall, rx_data_rise}`.
  - `gmii_rx_dv = rx_ctl_rise`.
  - `gmii_rx_er = rx_ctl_rise ^ rx_ctl_fall`.
- **In-band status.**
  - Sampled from stage 1 when `dv=0`, `er=0`, and rise nibble equals fall nibble.
  - Bit 0 drives `link_up`, bits 2:1 drive `link_speed`, bit 3 drives `full_duplex`.
  - Registered, so it updates one cycle after stage 1. It holds otherwise, including during frames.
- **Frame FSM** (operates on stage 1 outputs):
  - **IDLE**
    - `dv & data==0x55` → PREAMBLE, preamble count = 1.
    - `dv` with any other byte, or `dv & er` → DROP.
  - **PREAMBLE**
    - 0x55 → stay; count increments, saturating at 7.
    - 0xD5 with count ≥ `MIN_PREAMBLE` → PAYLOAD, length = 0, error = 0.
    - Any other byte, 0xD5 with too short a preamble, or `er` → DROP.
    - `!dv` → IDLE without counting a drop.
  - **PAYLOAD**
    - Each `dv` byte enters a one-byte hold register. The previously held byte is emitted with `frame_valid=1`, and `frame_sop=1` if it is the first byte.
    - Length increments, saturating at 0xFFFF.
    - `er` sets sticky error. Length > `MAX_FRAME` also sets sticky error.
    - On `!dv`, the held byte is emitted with `frame_eop=1`, `frame_err`, and final `frame_len`; then → IDLE.
    - `!dv` with zero payload bytes → IDLE, `drop_cnt`++, no output.
  - **DROP**
    - Entering DROP increments `drop_cnt`.
    - Remain in DROP until `!dv`, then → IDLE. No frame output.
- **Back-to-back frames.** A single IDLE cycle (`dv=0`) between frames is sufficient.
- **Reset mid-frame.** All frame outputs return to 0 on the next cycle and no EOP is produced. The next frame is received normally.
- **Single-cycle qualifiers.** `frame_valid`, `frame_sop` and `frame_eop` are single-cycle per byte. `frame_err` and `frame_len` are 0 whenever `frame_eop=0`.

## Timing
- `gmii_rx_*` is valid 1 cycle after the inputs are sampled.
- Status outputs are valid 2 cycles after a qualifying idle sample.
- Every payload byte, including the last, appears on `frame_data` exactly 3 cycles after its nibbles are presented on the inputs.
  - The EOP byte is released by the `dv=0` sample that follows it.
- At full rate the frame outputs can be valid on consecutive cycles. There is no backpressure; the consumer must accept every `frame_valid` cycle.
- `drop_cnt` updates 1 cycle after the stage 1 sample that causes the drop.

## Test plan
- **Clean 64-byte frame.** 7×0x55, 0xD5, payload 0x00..0x3F, then idle.
  - `frame_sop` with 0x00 arrives 3 cycles after the 0x00 input.
  - 64 consecutive `frame_valid` cycles.
  - `frame_eop` with 0x3F, `frame_len=64`, `frame_err=0`.
- **Mid-frame error.** Same frame, with `rx_ctl_fall=0` on payload byte 10.
  - `gmii_rx_er=1` for exactly one cycle.
  - EOP carries `frame_err=1`, `frame_len=64`.
- **Bad preamble.** 0x55, 0x54, then 20 bytes with `dv=1`.
  - No `frame_valid`; `drop_cnt` 0 → 1.
  - A following clean frame is received intact.
- **In-band status.** Idle with rise = fall = 0xD.
  - 2 cycles later: `link_up=1`, `link_speed=2`, `full_duplex=1`.
  - Then idle with rise=0x1, fall=0x3: status unchanged.
- **Reset mid-frame.** `sys_rst` pulsed for 1 cycle at payload byte 30.
  - Next cycle: all frame outputs 0, no EOP ever emitted for that frame.
  - Next frame: normal SOP/EOP.
- **Edge cases.**
  - SFD immediately followed by `dv=0` → no output, `drop_cnt`+1.
  - 1600-byte frame → EOP with `frame_len=1600`, `frame_err=1`.
